serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder front-end that feeds the 1-bit full_adder cell, LSB first, one bit per clock.
//  Accepts two WIDTH-bit operands and a carry-in over the TinyTapeout pins.
//  Accumulates the sum serially and presents the sum, carry-out, signed overflow and status flags.
//  Sits in the same user-project top slot, wrapping the full_adder as its datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..8, limited by the 8-bit ui_in/uo_out pins.
// PORTS
//  clk      in   1  single clock; all state changes on its rising edge.
//  rst_n    in   1  reset, asynchronous and active-low; clears all state.
//  ena      in   1  design-select; while low, all state holds (no load, no shift, no edge detect).
//  ui_in    in   8  operand data byte; only bits [WIDTH-1:0] are used.
//  uio_in   in   8  [0] load_a, [1] load_b, [2] start, [3] cin; bits [7:4] are ignored.
//  uo_out   out  8  last completed sum; zero-extended above WIDTH.
//  uio_out  out  8  [7] busy, [6] done, [5] cout, [4] ovf; bits [3:0] are 0.
//  uio_oe   out  8  constant 8'hF0.
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; opa, opb, carry, bit counter, sum register, start_q all 0.
//   - uo_out=0; uio_out=0 (busy, done, cout and ovf all 0).
//  Operand loads:
//   - Legal only in IDLE or DONE, with ena=1.
//   - load_a=1 sets opa<=ui_in on that edge; load_b=1 sets opb<=ui_in. Loads are level-sensitive.
//   - Both asserted together: both operands capture the same byte.
//   - In DONE, a load returns the FSM to IDLE and clears done; cout, ovf and uo_out keep their values.
//  Start:
//   - Rising-edge detected: start_q<=uio_in[2] every ena cycle; the edge is uio_in[2]&~start_q.
//   - Start held high launches exactly one operation.
//   - Start edge in IDLE/DONE: carry<=cin, count<=0, done<=0, state<=SHIFT.
//   - Start has priority over loads in the same cycle; those loads are dropped.
//   - Start edge during SHIFT: ignored. Loads during SHIFT: ignored.
//  SHIFT (each ena=1 edge):
//   - full_adder(a=opa[0], b=opb[0], ci=carry) produces s and co.
//   - psum <= {s, psum[WIDTH-1:1]}; opa and opb shift right (fill 0); carry<=co; count++.
//   - On the edge where count==WIDTH-1 (the final bit):
//     - sum register <= the completed psum, including s; cout<=co; ovf<=ci_msb^co;
//     - state<=DONE; done<=1.
//   - ci_msb is the carry into the MSB, i.e. the carry register value on the final bit.
//  Latency: start edge sampled at edge N -> WIDTH shift edges N+1..N+WIDTH -> done=1 and the result is valid after edge N+WIDTH.
//  ena=0 mid-SHIFT freezes everything; latency is extended by the number of ena-low cycles.
//  busy = (state==SHIFT). done stays high in DONE until the next start edge or load.
//  During SHIFT, uo_out, cout and ovf keep the previous result; they never show partial sums.
//  Reset asserted mid-operation: immediate return to reset values; no result is latched.
//  Wrap-around: overflow beyond WIDTH appears only on cout; the sum is truncated to WIDTH bits.
//  FSM states: IDLE -> SHIFT (start edge); SHIFT -> DONE (final bit); DONE -> SHIFT (start edge); DONE -> IDLE (load).
// STRUCTURE
//  Shared package serial_adder_pkg:
//   - State enum/localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
//   - uio bit-index constants (LOAD_A=0, LOAD_B=1, START=2, CIN=3, OVF=4, COUT=5, DONE=6, BUSY=7).
//   - UIO_OE_MASK=8'hF0.
//  One sub-module: full_adder (combinational; a, b, ci -> s, co), instantiated once.
//  This module holds the FSM, operand shift registers, carry FF, counter ($clog2(WIDTH) bits) and start edge detector.
// TESTING
//  1. Load A=0x35, B=0x4A, cin=0, start -> after 8 shift edges: uo_out=0x7F, cout=0, ovf=0, done=1, busy=0.
//  2. A=0xFF, B=0x01, cin=0 -> uo_out=0x00, cout=1, ovf=0. A=0x7F, B=0x01 -> uo_out=0x80, cout=0, ovf=1.
//  3. A=0xFF, B=0x00, cin=1 -> uo_out=0x00, cout=1. A=0x80, B=0x80, cin=0 -> uo_out=0x00, cout=1, ovf=1.
//  4. Start held high 30 cycles -> exactly one operation; done stays 1; a second start edge reruns and clears done for 8 cycles.
//  5. ena=0 for 3 cycles mid-SHIFT -> done arrives 3 cycles later, result unchanged; load/start pulses during SHIFT have no effect.
//  6. rst_n low at shift bit 4 -> all outputs 0, busy=0, done=0 immediately; a fresh load+start then completes correctly.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM states and TinyTapeout uio pin map for the serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
    localparam int LOAD_A = 0;
    localparam int LOAD_B = 1;
    localparam int START  = 2;
    localparam int CIN    = 3;
    localparam int OVF    = 4;
    localparam int COUT   = 5;
    localparam int DONE   = 6;
    localparam int BUSY   = 7;
    localparam logic [7:0] UIO_OE_MASK = 8'hF0;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit combinational full adder cell, the serial datapath
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder controller around a single full_adder
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_d;
    logic [WIDTH-1:0] opa, opb, psum, sum;
    logic [CW-1:0] count;
    logic carry, cout, ovf, start_q, s, co, start_edge, load, last, busy, done;
    logic unused_ok;
    full_adder u_fa (.a(opa[0]), .b(opb[0]), .ci(carry), .s(s), .co(co));
    assign start_edge = uio_in[START] & ~start_q;
    assign load       = uio_in[LOAD_A] | uio_in[LOAD_B];
    assign last       = count == CW'(WIDTH - 1);
    assign busy       = state == ST_SHIFT;
    assign done       = state == ST_DONE;
    assign unused_ok  = &{1'b0, ui_in, uio_in[7:4]};
    always_comb begin
        state_d = !ena ? state
                : busy ? (last ? ST_DONE : ST_SHIFT)
                : start_edge ? ST_SHIFT
                : (done && !load) ? ST_DONE : ST_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end
    // start priority over loads outside SHIFT; everything frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            psum    <= '0;
            sum     <= '0;
            count   <= '0;
            carry   <= 1'b0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            start_q <= 1'b0;
        end else if (ena) begin
            start_q <= uio_in[START];
            if (busy) begin
                opa   <= opa >> 1;
                opb   <= opb >> 1;
                psum  <= {s, psum[WIDTH-1:1]};
                carry <= co;
                count <= count + 1'b1;
                if (last) begin
                    sum  <= {s, psum[WIDTH-1:1]};
                    cout <= co;
                    ovf  <= carry ^ co;
                end
            end else if (start_edge) begin
                carry <= uio_in[CIN];
                count <= '0;
            end else begin
                if (uio_in[LOAD_A]) opa <= ui_in[WIDTH-1:0];
                if (uio_in[LOAD_B]) opb <= ui_in[WIDTH-1:0];
            end
        end
    end
    always_comb begin
        uio_out       = '0;
        uio_out[BUSY] = busy;
        uio_out[DONE] = done;
        uio_out[COUT] = cout;
        uio_out[OVF]  = ovf;
    end
    assign uo_out = 8'(sum);
    assign uio_oe = UIO_OE_MASK;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of the serial adder against an arithmetic model
module tb_serial_adder_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic [7:0] ui_in = '0, uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;
    int checks = 0, errors = 0;
    logic [7:0] exp_sum = '0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // returns {ovf, cout, sum[7:0]}
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        logic v;
        t = 9'(a) + 9'(b) + 9'(c);
        v = (a[7] == b[7]) && (t[7] != a[7]);
        return {v, t};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input int gap, input bit noise);
        logic [9:0] e;
        int n;
        e = model(a, b, c);
        ui_in = a; uio_in = 8'h01; step;
        check("done_after_load", uio_out[6], 0);
        ui_in = b; uio_in = 8'h02; step;
        ui_in = 8'($urandom); uio_in = {4'h0, c, 3'b100}; step;
        check("busy_after_start", uio_out[7], 1);
        n = 0;
        while (!uio_out[6] && n < 100) begin
            ena = !(n >= 3 && n < 3 + gap);
            if (noise && n >= 1 && n <= 5) begin
                ui_in = 8'($urandom);
                uio_in = 8'($urandom_range(0, 7));
            end else uio_in = {4'h0, c, 3'b000};
            step;
            n++;
            if (n == 2) check("no_partial_sum", uo_out, exp_sum);
        end
        ena = 1'b1; uio_in = '0;
        check("latency", n, 8 + gap);
        check("sum", uo_out, e[7:0]);
        check("cout", uio_out[5], e[8]);
        check("ovf", uio_out[4], e[9]);
        check("busy_clear", uio_out[7], 0);
        check("low_uio_bits", uio_out[3:0], 0);
        exp_sum = e[7:0];
    endtask

    initial begin
        int busy_cnt, n;
        #1;
        check("rst_uo_out", uo_out, 0);
        check("rst_uio_out", uio_out, 0);
        check("uio_oe", uio_oe, 8'hF0);
        step;
        rst_n = 1'b1;
        step;
        run_op(8'h35, 8'h4A, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 0);
        run_op(8'hFF, 8'h00, 1'b1, 0, 0);
        run_op(8'h80, 8'h80, 1'b0, 0, 0);
        // start held high launches one operation only
        ui_in = 8'h12; uio_in = 8'h01; step;
        ui_in = 8'h34; uio_in = 8'h02; step;
        busy_cnt = 0;
        uio_in = 8'h04;
        repeat (30) begin
            step;
            busy_cnt += int'(uio_out[7]);
        end
        check("held_start_busy_cycles", busy_cnt, 8);
        check("held_start_done", uio_out[6], 1);
        check("held_start_sum", uo_out, 8'h46);
        uio_in = 8'h00; step;
        uio_in = 8'h0C; step;
        check("rerun_done_clear", uio_out[6], 0);
        check("rerun_busy", uio_out[7], 1);
        n = 0;
        while (!uio_out[6] && n < 100) begin
            step;
            n++;
        end
        check("rerun_latency", n, 8);
        check("rerun_sum", uo_out, 8'h01);
        uio_in = '0; step;
        exp_sum = 8'h01;
        run_op(8'h5A, 8'h3C, 1'b0, 3, 1);
        run_op(8'hC3, 8'h99, 1'b1, 2, 1);
        // reset in the middle of an operation
        ui_in = 8'hAA; uio_in = 8'h03; step;
        uio_in = 8'h04; step;
        uio_in = 8'h00;
        repeat (4) step;
        rst_n = 1'b0;
        #1;
        check("midrst_uo_out", uo_out, 0);
        check("midrst_uio_out", uio_out, 0);
        step;
        rst_n = 1'b1;
        exp_sum = '0;
        step;
        run_op(8'h35, 8'h4A, 1'b0, 0, 0);
        repeat (25) run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
